multi_encoder: RTL
==================

MULTI_ENCODER -- requirements
Module: multi_encoder

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent quadrature channels.
REQ-002 Parameter WIDTH, default 8: bits per channel count.
REQ-003 Parameter STEP, default 1: magnitude added or subtracted per counted transition; WIDTH bits, legal range 1..2^WIDTH-1.
REQ-004 Parameter SATURATE, default 0: 0 means counts wrap modulo 2^WIDTH; 1 means counts clamp to 0..2^WIDTH-1.
REQ-005 Parameter DEBOUNCE_CYCLES, default 4: stability window for the optional filter; legal range 1..255.
REQ-006 clk  input  1  sole clock, rising-edge active.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 a  input  CHANNELS  quadrature phase A per channel, asynchronous to clk.
REQ-009 b  input  CHANNELS  quadrature phase B per channel, asynchronous to clk.
REQ-010 mode  input  2  resolution: 00 = x1, 01 = x2, 10 and 11 = x4.
REQ-011 clear  input  1  synchronous clear of all counts and error flags.
REQ-012 value  output  CHANNELS*WIDTH  channel n count at bits [n*WIDTH +: WIDTH].
REQ-013 step  output  CHANNELS  one-cycle pulse, high in the cycle a channel's value changes.
REQ-014 dir  output  CHANNELS  direction of the last counted transition: 1 = up, 0 = down.
REQ-015 error  output  CHANNELS  sticky flag for an illegal transition.

Function
REQ-016 Each channel SHALL pass a and b through a 2-flop synchroniser; the synchronised pair {A,B} is the channel state.
REQ-017 The forward sequence SHALL be 00->10->11->01->00 (A leads B); the reverse sequence is the opposite order.
REQ-018 x4: every legal state change SHALL count, +STEP forward and -STEP reverse.
REQ-019 x2: only changes of A SHALL count: +STEP on 00->10 and 11->01; -STEP on 10->00 and 01->11.
REQ-020 x1: only +STEP on 10->11 and -STEP on 11->10 SHALL count.
REQ-021 Transitions 00<->11 and 10<->01 SHALL be illegal: no count, and the channel's error bit is set.
REQ-022 A state change that does not count in the current mode SHALL leave value, step and dir unchanged.
REQ-023 Without the debounce filter, value SHALL update on the 3rd rising clk edge after an input change meets setup, with step high for that one cycle.
REQ-024 Wrap mode: arithmetic SHALL be modulo 2^WIDTH (example: 255+1 = 0, 0-1 = 255 at WIDTH=8).
REQ-025 Saturate mode: a result above 2^WIDTH-1 SHALL clamp to 2^WIDTH-1 and a result below 0 SHALL clamp to 0.
REQ-026 In saturate mode, step SHALL pulse only if the stored value actually changes; dir SHALL still update.
REQ-027 clear SHALL take priority over a same-cycle count: all values and error bits go to 0, step stays 0, and dir is unchanged.
REQ-028 A mode change SHALL take effect on the next evaluated transition; the tracked previous state is retained.
REQ-029 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be counted in the same cycle.

Reset
REQ-030 While reset is high: value = 0, step = 0, dir = 0, error = 0, and all synchroniser, filter and previous-state flops = 0.
REQ-031 For ARM cycles after reset deasserts, the previous state SHALL track the current state with counting and error detection suppressed.
REQ-032 ARM SHALL be 3 without the debounce filter and 3+DEBOUNCE_CYCLES with it.
REQ-033 Reset asserted mid-operation SHALL immediately return all outputs to their reset values, regardless of clk.

Configuration
REQ-034 Macro ENCODER_DEBOUNCE_EN, when defined, SHALL insert a per-channel, per-phase filter after the synchroniser.
REQ-035 With the filter, a phase change SHALL propagate only after DEBOUNCE_CYCLES consecutive cycles at the new level; any glitch shorter than that is ignored.
REQ-036 With the filter, the REQ-023 latency SHALL increase by DEBOUNCE_CYCLES.
REQ-037 Without ENCODER_DEBOUNCE_EN, no filter logic SHALL be synthesised.

Verification (CHANNELS=3, WIDTH=8, STEP=1, macro undefined unless stated)
REQ-038 x4 wrap, ch0 driven 4 forward full cycles (16 transitions) -> value[7:0] = 16, 16 step pulses, dir[0] = 1; ch1 and ch2 stay 0.
REQ-039 x1 ch1 reverse 3 full cycles from 0 in wrap mode -> value[15:8] = 253; same stimulus with SATURATE=1 -> value stays 0, no step pulse, dir[1] = 0.
REQ-040 ch2 jumps 00->11 -> error[2] = 1 and value unchanged; then clear pulse coincident with a legal forward transition on ch0 -> all values 0, error 0, step 0.
REQ-041 x2, ch0 at value 255 with wrap, one forward A edge -> value 0 on the 3rd edge after the input change, with a single-cycle step.
REQ-042 Macro defined, DEBOUNCE_CYCLES=4, a 3-cycle glitch on a[0] -> no count; a 4-cycle stable edge -> count 7 cycles after the input change.
REQ-043 a = b = all ones held through reset release -> no error and no count during ARM; a subsequent legal 11->01 in x4 -> +1.

Source files
------------

// File: rtl/multi_encoder.sv
`default_nettype none
// ============================================================================
// Module   : multi_encoder
// Purpose  : Multi-channel quadrature encoder counter. Each channel
//            synchronises its A/B phases, decodes the Gray-code state
//            sequence and steps a WIDTH-bit count up or down according to the
//            selected resolution (x1 / x2 / x4). Counts either wrap or
//            saturate. Illegal two-bit jumps raise a sticky error flag.
// Ports    : clk    - sole clock, rising edge
//            reset  - asynchronous active-high reset
//            a, b   - per-channel quadrature phases (asynchronous to clk)
//            mode   - 00 = x1, 01 = x2, 1x = x4
//            clear  - synchronous clear of counts and error flags
//            value  - channel n count at [n*WIDTH +: WIDTH]
//            step   - one-cycle pulse when a channel's value changes
//            dir    - direction of last counted transition (1 = up)
//            error  - sticky illegal-transition flag per channel
// Options  : define ENCODER_DEBOUNCE_EN to insert a per-phase stability
//            filter of DEBOUNCE_CYCLES after the synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module multi_encoder #(
  parameter int CHANNELS        = 3,
  parameter int WIDTH           = 8,
  parameter int STEP            = 1,
  parameter int SATURATE        = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  input  logic [1:0]                mode,
  input  logic                      clear,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       step,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       error
);

`ifdef ENCODER_DEBOUNCE_EN
  localparam bit c_filter_en = 1'b1;
  localparam int c_db_w      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
`else
  localparam bit c_filter_en = 1'b0;
`endif

  // Cycles after reset release during which the previous-state register is
  // only primed: the synchroniser (and filter) pipeline still holds reset
  // zeros, so the first real state would otherwise look like a transition.
  localparam int c_arm   = 3 + (c_filter_en ? DEBOUNCE_CYCLES : 0);
  localparam int c_arm_w = $clog2(c_arm + 1);
  localparam logic [c_arm_w-1:0] c_arm_last = c_arm_w'(c_arm);
  localparam logic [WIDTH-1:0]   c_step     = WIDTH'(STEP);
  localparam bit                 c_saturate = (SATURATE != 0);

  logic [c_arm_w-1:0] r_arm_cnt;
  logic               w_armed;

  assign w_armed = (r_arm_cnt == c_arm_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + c_arm_w'(1);
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    logic [1:0]       r_sync_a;
    logic [1:0]       r_sync_b;
    logic [1:0]       w_raw;      // synchronised {A,B}
    logic [1:0]       w_state;    // {A,B} as seen by the decoder
    logic [1:0]       r_prev;
    logic [WIDTH-1:0] r_value;
    logic             r_step;
    logic             r_dir;
    logic             r_error;
    logic             w_fwd;
    logic             w_rev;
    logic             w_illegal;
    logic             w_qualify;
    logic             w_up;
    logic             w_dn;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_next;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync_a <= '0;
        r_sync_b <= '0;
      end else begin
        r_sync_a <= {r_sync_a[0], a[n]};
        r_sync_b <= {r_sync_b[0], b[n]};
      end
    end

    assign w_raw = {r_sync_a[1], r_sync_b[1]};

`ifdef ENCODER_DEBOUNCE_EN
    // A phase only moves once the synchronised level has differed from the
    // filtered level for DEBOUNCE_CYCLES consecutive samples.
    for (genvar p = 0; p < 2; p++) begin : g_filter
      logic              r_filt;
      logic [c_db_w-1:0] r_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_filt <= 1'b0;
          r_cnt  <= '0;
        end else if (w_raw[p] == r_filt) begin
          r_cnt  <= '0;
        end else if (r_cnt == c_db_last) begin
          r_filt <= w_raw[p];
          r_cnt  <= '0;
        end else begin
          r_cnt  <= r_cnt + c_db_w'(1);
        end
      end

      assign w_state[p] = r_filt;
    end
`else
    assign w_state = w_raw;
`endif

    // Forward order is 00 -> 10 -> 11 -> 01 -> 00; two-bit jumps are illegal.
    always_comb begin
      w_fwd     = 1'b0;
      w_rev     = 1'b0;
      w_illegal = 1'b0;
      case ({r_prev, w_state})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_fwd     = 1'b1;
        4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: w_rev     = 1'b1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: w_illegal = 1'b1;
        default: ;
      endcase

      // x1 counts only the 10<->11 edge, i.e. B moving while A stays high.
      // x2 counts only edges where A moves.
      case (mode)
        2'b00:   w_qualify = r_prev[1] & w_state[1];
        2'b01:   w_qualify = r_prev[1] ^ w_state[1];
        default: w_qualify = 1'b1;
      endcase

      w_up   = w_fwd & w_qualify;
      w_dn   = w_rev & w_qualify;
      w_sum  = {1'b0, r_value} + {1'b0, c_step};
      w_diff = {1'b0, r_value} - {1'b0, c_step};

      w_next = r_value;
      if (w_up) begin
        w_next = (c_saturate && w_sum[WIDTH]) ? '1 : w_sum[WIDTH-1:0];
      end else if (w_dn) begin
        w_next = (c_saturate && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_prev  <= '0;
        r_value <= '0;
        r_step  <= 1'b0;
        r_dir   <= 1'b0;
        r_error <= 1'b0;
      end else begin
        // The previous state always follows, even while arming or clearing,
        // so a mode change never loses track of position.
        r_prev <= w_state;
        r_step <= 1'b0;
        if (clear) begin
          r_value <= '0;
          r_error <= 1'b0;
        end else if (w_armed) begin
          if (w_illegal) begin
            r_error <= 1'b1;
          end
          if (w_up || w_dn) begin
            r_dir   <= w_up;
            r_value <= w_next;
            // A clamped count still updates direction but does not pulse.
            r_step  <= (w_next != r_value);
          end
        end
      end
    end

    assign value[n*WIDTH +: WIDTH] = r_value;
    assign step[n]                 = r_step;
    assign dir[n]                  = r_dir;
    assign error[n]                = r_error;
  end

endmodule
`default_nettype wire
